// File: rtl/obj_track_arb.sv
// Debounces N_CH sensor lines, locks onto one object (fixed-priority or round-robin pick) and rides out short drop-outs.
// Latency: 2 sync + DEB_CYCLES debounce + 1 FSM edge to lock; registered outputs, no backpressure (pulses are single-cycle).
module obj_track_arb #(
  parameter  int N_CH        = 3,
  parameter  int DEB_CYCLES  = 4,
  parameter  int HOLD_CYCLES = 8,
  localparam int ID_W        = ($clog2(N_CH) < 1) ? 1 : $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic            rr_mode,
  input  logic [N_CH-1:0] sensor_in,
  output logic [N_CH-1:0] det_stable,
  output logic            obj_valid,
  output logic [N_CH-1:0] obj_onehot,
  output logic [ID_W-1:0] obj_id,
  output logic            new_obj,
  output logic            lost_obj
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int HW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LD  = HW'(HOLD_CYCLES);

  typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

  logic [N_CH-1:0] sync1, sync2, det_q;
  logic [CW-1:0]   deb_cnt [N_CH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      det_q <= '0;
      for (int i = 0; i < N_CH; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= sensor_in;
      sync2 <= sync1;
      for (int i = 0; i < N_CH; i++) begin
        if (sync2[i] != det_q[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            det_q[i]   <= ~det_q[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + CW'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  state_t          state, state_n;
  logic [ID_W-1:0] cur_id, cur_n, last_id, last_n;
  logic [HW-1:0]   hold_cnt, hold_n;
  logic            valid_q, valid_n, new_q, new_n, lost_q, lost_n;
  logic [ID_W-1:0] id_q, id_n;
  logic [N_CH-1:0] onehot_q, onehot_n;
  logic [ID_W-1:0] win_fix, win_hi, winner;
  logic            found_hi;

  // Round-robin: lowest set index above last_id, else wrap to the lowest set index.
  always_comb begin
    win_fix  = '0;
    win_hi   = '0;
    found_hi = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (det_q[i]) win_fix = ID_W'(i);
      if (det_q[i] && (ID_W'(i) > last_id)) begin
        win_hi   = ID_W'(i);
        found_hi = 1'b1;
      end
    end
    winner = (rr_mode && found_hi) ? win_hi : win_fix;
  end

  always_comb begin
    state_n = state;
    cur_n   = cur_id;
    last_n  = last_id;
    hold_n  = hold_cnt;
    new_n   = 1'b0;
    lost_n  = 1'b0;
    case (state)
      IDLE: begin
        if (enable && (|det_q)) begin
          state_n = TRACK;
          cur_n   = winner;
          last_n  = winner;
          new_n   = 1'b1;
        end
      end
      TRACK: begin
        if (!enable) begin
          state_n = IDLE;
          lost_n  = 1'b1;
        end else if (!det_q[cur_id]) begin
          if (HOLD_CYCLES > 0) begin
            state_n = HOLD;
            hold_n  = HOLD_LD;
          end else begin
            state_n = IDLE;
            lost_n  = 1'b1;
          end
        end
      end
      HOLD: begin
        // Reassertion is checked before expiry so it wins a tie.
        if (!enable) begin
          state_n = IDLE;
          lost_n  = 1'b1;
        end else if (det_q[cur_id]) begin
          state_n = TRACK;
        end else if (hold_cnt <= HW'(1)) begin
          state_n = IDLE;
          lost_n  = 1'b1;
        end else begin
          hold_n = hold_cnt - HW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    valid_n  = (state_n != IDLE);
    id_n     = valid_n ? cur_n : '0;
    onehot_n = valid_n ? (N_CH'(1) << cur_n) : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cur_id   <= '0;
      last_id  <= ID_W'(N_CH - 1);
      hold_cnt <= '0;
      valid_q  <= 1'b0;
      id_q     <= '0;
      onehot_q <= '0;
      new_q    <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state    <= state_n;
      cur_id   <= cur_n;
      last_id  <= last_n;
      hold_cnt <= hold_n;
      valid_q  <= valid_n;
      id_q     <= id_n;
      onehot_q <= onehot_n;
      new_q    <= new_n;
      lost_q   <= lost_n;
    end
  end

  assign det_stable = det_q;
  assign obj_valid  = valid_q;
  assign obj_id     = id_q;
  assign obj_onehot = onehot_q;
  assign new_obj    = new_q;
  assign lost_obj   = lost_q;

endmodule

// File: tb/tb_obj_track_arb.sv
// Directed bench for obj_track_arb with a window-based behavioural model checked every cycle.
module tb_obj_track_arb;

  localparam int N    = 3;
  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int IW   = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          rr_mode;
  logic [N-1:0]  sensor_in;
  logic [N-1:0]  det_stable;
  logic          obj_valid;
  logic [N-1:0]  obj_onehot;
  logic [IW-1:0] obj_id;
  logic          new_obj;
  logic          lost_obj;

  obj_track_arb #(.N_CH(N), .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .rr_mode(rr_mode),
    .sensor_in(sensor_in), .det_stable(det_stable), .obj_valid(obj_valid),
    .obj_onehot(obj_onehot), .obj_id(obj_id), .new_obj(new_obj), .lost_obj(lost_obj)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic nwait(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: det flips once the last DEB synchronised samples all disagree with it.
  int m_s1 [N];
  int m_s2 [N];
  int m_det [N];
  int hist [N][DEB];
  int m_lock, m_last, m_left, m_in_hold, m_new, m_lost;

  function automatic int m_det_vec();
    int v = 0;
    for (int i = 0; i < N; i++) v += m_det[i] << i;
    return v;
  endfunction

  function automatic int pick(input int rr);
    if (rr != 0) begin
      for (int k = 1; k <= N; k++)
        if (m_det[(m_last + k) % N] != 0) return (m_last + k) % N;
    end
    for (int i = 0; i < N; i++) if (m_det[i] != 0) return i;
    return -1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_det[i] = 0;
        for (int j = 0; j < DEB; j++) hist[i][j] = 0;
      end
      m_lock = -1; m_last = N - 1; m_left = 0; m_in_hold = 0; m_new = 0; m_lost = 0;
    end else begin
      m_new = 0;
      m_lost = 0;
      if (m_lock < 0) begin
        if (enable && m_det_vec() != 0) begin
          m_lock = pick(int'(rr_mode));
          m_last = m_lock;
          m_new = 1;
          m_in_hold = 0;
        end
      end else if (!enable) begin
        m_lock = -1; m_lost = 1;
      end else if (m_det[m_lock] != 0) begin
        m_in_hold = 0;
      end else if (m_in_hold == 0) begin
        m_in_hold = 1; m_left = HOLD;
      end else begin
        m_left--;
        if (m_left == 0) begin m_lock = -1; m_lost = 1; end
      end
      for (int i = 0; i < N; i++) begin
        bit all_diff;
        for (int j = DEB - 1; j > 0; j--) hist[i][j] = hist[i][j-1];
        hist[i][0] = m_s2[i];
        all_diff = 1'b1;
        for (int j = 0; j < DEB; j++) if (hist[i][j] == m_det[i]) all_diff = 1'b0;
        if (all_diff) m_det[i] = 1 - m_det[i];
        m_s2[i] = m_s1[i];
        m_s1[i] = int'(sensor_in[i]);
      end
    end
  end

  always @(negedge clk) begin
    int ev, eid, eoh;
    ev  = (m_lock >= 0) ? 1 : 0;
    eid = (m_lock >= 0) ? m_lock : 0;
    eoh = (m_lock >= 0) ? (1 << m_lock) : 0;
    chk("det_stable", int'(det_stable), m_det_vec());
    chk("obj_valid", int'(obj_valid), ev);
    chk("obj_id", int'(obj_id), eid);
    chk("obj_onehot", int'(obj_onehot), eoh);
    chk("new_obj", int'(new_obj), m_new);
    chk("lost_obj", int'(lost_obj), m_lost);
    chk("pulse_excl", int'(new_obj & lost_obj), 0);
  end

  initial begin
    reset_n = 1'b1; enable = 1'b1; rr_mode = 1'b0; sensor_in = '0;
    #1 reset_n = 1'b0;
    nwait(3);
    chk("rst_valid", int'(obj_valid), 0);
    chk("rst_det", int'(det_stable), 0);
    reset_n = 1'b1;

    // Short pulse: 3 cycles high never reaches det_stable.
    sensor_in = 3'b001;
    nwait(3);
    sensor_in = 3'b000;
    nwait(10);
    chk("glitch_det", int'(det_stable), 0);
    chk("glitch_valid", int'(obj_valid), 0);

    // Held high: det rises on the 5th edge after the sampling edge, lock one edge later.
    sensor_in = 3'b001;
    nwait(5);
    chk("deb_pre_det", int'(det_stable), 0);
    nwait(1);
    chk("deb_det", int'(det_stable), 1);
    chk("deb_pre_valid", int'(obj_valid), 0);
    nwait(1);
    chk("acq_valid", int'(obj_valid), 1);
    chk("acq_id", int'(obj_id), 0);
    chk("acq_onehot", int'(obj_onehot), 1);
    chk("acq_new", int'(new_obj), 1);
    nwait(1);
    chk("acq_new_drop", int'(new_obj), 0);
    sensor_in = 3'b000;
    nwait(20);
    chk("t1_idle", int'(obj_valid), 0);

    // Fixed priority and lock-on.
    sensor_in = 3'b110;
    nwait(8);
    chk("prio_id", int'(obj_id), 1);
    chk("prio_onehot", int'(obj_onehot), 2);
    sensor_in = 3'b111;
    nwait(8);
    chk("lock_id", int'(obj_id), 1);
    sensor_in = 3'b000;
    nwait(20);
    chk("t2_idle", int'(obj_valid), 0);

    // Hold window: a 5-cycle drop-out is ridden out, a sustained one expires after 8 HOLD cycles.
    sensor_in = 3'b100;
    nwait(8);
    chk("hold_id", int'(obj_id), 2);
    sensor_in = 3'b000;
    nwait(5);
    sensor_in = 3'b100;
    for (int i = 0; i < 14; i++) begin
      nwait(1);
      chk("ride_valid", int'(obj_valid), 1);
      chk("ride_lost", int'(lost_obj), 0);
      chk("ride_new", int'(new_obj), 0);
    end
    chk("ride_det", int'(det_stable), 4);
    sensor_in = 3'b000;
    nwait(14);
    chk("hold_last_valid", int'(obj_valid), 1);
    nwait(1);
    chk("hold_exp_valid", int'(obj_valid), 0);
    chk("hold_exp_lost", int'(lost_obj), 1);
    nwait(1);
    chk("hold_lost_drop", int'(lost_obj), 0);

    // Round-robin: last lock was ch2, so ch0 first, then each enable pulse advances.
    rr_mode = 1'b1;
    sensor_in = 3'b111;
    nwait(7);
    chk("rr_first_id", int'(obj_id), 0);
    chk("rr_first_new", int'(new_obj), 1);
    nwait(2);
    for (int k = 0; k < 4; k++) begin
      enable = 1'b0;
      nwait(1);
      chk("rr_lost", int'(lost_obj), 1);
      chk("rr_gap_valid", int'(obj_valid), 0);
      enable = 1'b1;
      nwait(1);
      chk("rr_new", int'(new_obj), 1);
      chk("rr_id", int'(obj_id), (k + 1) % N);
      nwait(2);
    end

    // Enable abort in TRACK (last lock ch1).
    enable = 1'b0;
    nwait(1);
    chk("abort_valid", int'(obj_valid), 0);
    chk("abort_id", int'(obj_id), 0);
    chk("abort_lost", int'(lost_obj), 1);
    chk("abort_det", int'(det_stable), 7);
    nwait(1);
    chk("abort_lost_drop", int'(lost_obj), 0);
    chk("abort_stay_idle", int'(obj_valid), 0);
    enable = 1'b1;
    nwait(1);
    chk("reacq_id", int'(obj_id), 2);

    // Async reset in the middle of HOLD.
    sensor_in = 3'b000;
    nwait(9);
    chk("in_hold_valid", int'(obj_valid), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", int'(obj_valid), 0);
    chk("arst_id", int'(obj_id), 0);
    chk("arst_onehot", int'(obj_onehot), 0);
    chk("arst_det", int'(det_stable), 0);
    chk("arst_pulses", int'(new_obj) + int'(lost_obj), 0);
    nwait(1);
    reset_n = 1'b1;
    nwait(10);
    chk("post_rst_idle", int'(obj_valid), 0);
    sensor_in = 3'b111;
    nwait(7);
    chk("post_rst_rr_id", int'(obj_id), 0);
    chk("post_rst_new", int'(new_obj), 1);
    nwait(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
